// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - UART boot loader: loads RAM images, starts the cpu, hands over the UART
//
// Purpose: owns the UART while the cpu is stopped. Commands:
//   'L' ahi alo len data... csum -> write len bytes (0 = 256) from {ahi,alo}, reply ACK/NAK
//   'G' ahi alo                  -> start the cpu at {ahi,alo}, reply 'H' when it halts
//   'R' ahi alo len              -> stream len bytes of RAM back, then ACK (LOADER_READBACK_EN only)
// Optional feature macro: LOADER_READBACK_EN (undefined: raddr held 0, 'R' ignored).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   received, rx_byte           UART receive strobe and data
//   is_transmitting             UART transmitter busy
//   tx_byte, transmit           UART transmit data and strobe
//   waddr, wdata, write_en      RAM write port
//   raddr, rdata                RAM read port (rdata valid 2 clocks after raddr)
//   startaddr, cpu_start        cpu start address and start pulse
//   cpu_halted, cpu_running     cpu halted pulse, cpu owns UART/RAM write port
module uart_loader #(
    parameter int          addr_width     = 9,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  received,
    input  logic [7:0]            rx_byte,
    input  logic                  is_transmitting,
    output logic [7:0]            tx_byte,
    output logic                  transmit,
    output logic [addr_width-1:0] waddr,
    output logic [7:0]            wdata,
    output logic                  write_en,
    output logic [addr_width-1:0] raddr,
    input  logic [7:0]            rdata,
    output logic [addr_width-1:0] startaddr,
    output logic                  cpu_start,
    input  logic                  cpu_halted,
    output logic                  cpu_running
);
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    typedef enum logic [4:0] {
        IDLE, L_AHI, L_ALO, L_LEN, L_DATA, L_CSUM, G_AHI, G_ALO, START, RUN, REPLY,
        R_AHI, R_ALO, R_LEN, R_ADDR, R_W1, R_W2, R_TX
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            hi_q, hi_d, sum_q, sum_d, reply_q, reply_d, tx_byte_q, tx_byte_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [addr_width-1:0] cur_q, cur_d, waddr_q, waddr_d, startaddr_q, startaddr_d;
    logic [8:0]            cnt_q, cnt_d;
    logic [23:0]           tmo_q, tmo_d;
    logic                  transmit_q, transmit_d, write_en_q, write_en_d;
    logic                  cpu_start_q, cpu_start_d, running_q, running_d;
    logic                  count_en;
    logic [15:0]           addr_full;
    logic [8:0]            len_rx;

    assign addr_full = {hi_q, rx_byte};
    assign len_rx    = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};

`ifdef LOADER_READBACK_EN
    logic [addr_width-1:0] raddr_q, raddr_d;
    assign raddr = raddr_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^rdata;
    assign raddr        = '0;
`endif

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        reply_d     = reply_q;
        tx_byte_d   = tx_byte_q;
        transmit_d  = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        write_en_d  = 1'b0;
        startaddr_d = startaddr_q;
        cpu_start_d = 1'b0;
        running_d   = running_q;
        count_en    = 1'b0;
        tmo_d       = 24'd0;
`ifdef LOADER_READBACK_EN
        raddr_d     = raddr_q;
`endif
        case (state_q)
            IDLE: if (received) begin
                case (rx_byte)
                    8'h4C: begin sum_d = 8'd0; state_d = L_AHI; end
                    8'h47: state_d = G_AHI;
`ifdef LOADER_READBACK_EN
                    8'h52: state_d = R_AHI;
`endif
                    default: ;
                endcase
            end
            L_AHI, G_AHI, R_AHI: begin
                count_en = 1'b1;
                if (received) begin
                    hi_d    = rx_byte;
                    state_d = (state_q == L_AHI) ? L_ALO : (state_q == G_AHI) ? G_ALO : R_ALO;
                end
            end
            L_ALO, G_ALO, R_ALO: begin
                count_en = 1'b1;
                if (received) begin
                    cur_d   = addr_full[addr_width-1:0];
                    state_d = (state_q == L_ALO) ? L_LEN : (state_q == G_ALO) ? START : R_LEN;
                end
            end
            L_LEN, R_LEN: begin
                count_en = 1'b1;
                if (received) begin
                    cnt_d   = len_rx;
                    state_d = (state_q == L_LEN) ? L_DATA : R_ADDR;
                end
            end
            L_DATA: begin
                count_en = 1'b1;
                if (received) begin
                    write_en_d = 1'b1;
                    waddr_d    = cur_q;
                    wdata_d    = rx_byte;
                    cur_d      = cur_q + 1'b1;
                    sum_d      = sum_q + rx_byte;
                    cnt_d      = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) state_d = L_CSUM;
                end
            end
            L_CSUM: begin
                count_en = 1'b1;
                if (received) begin
                    reply_d = (rx_byte == sum_q) ? ACK : NAK;
                    state_d = REPLY;
                end
            end
            START: begin
                startaddr_d = cur_q;
                cpu_start_d = 1'b1;
                running_d   = 1'b1;
                state_d     = RUN;
            end
            RUN: if (cpu_halted) begin
                reply_d   = 8'h48;
                running_d = 1'b0;
                state_d   = REPLY;
            end
            REPLY: begin
                // transmit_q guard: the UART raises busy one clock after our strobe
                if (!is_transmitting && !transmit_q) begin
                    tx_byte_d  = reply_q;
                    transmit_d = 1'b1;
                    state_d    = IDLE;
                end
            end
`ifdef LOADER_READBACK_EN
            R_ADDR: begin raddr_d = cur_q; state_d = R_W1; end
            R_W1:   state_d = R_W2;
            R_W2:   state_d = R_TX;
            R_TX: begin
                if (!is_transmitting && !transmit_q) begin
                    tx_byte_d  = rdata;
                    transmit_d = 1'b1;
                    cur_d      = cur_q + 1'b1;
                    cnt_d      = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        reply_d = ACK;
                        state_d = REPLY;
                    end else begin
                        state_d = R_ADDR;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // A byte arriving in the expiry cycle wins: the received check comes first.
        if (!received && count_en) begin
            if (tmo_q == TIMEOUT_CYCLES - 24'd1) begin
                reply_d = NAK;
                state_d = REPLY;
            end else begin
                tmo_d = tmo_q + 24'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hi_q        <= '0;
            cur_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            reply_q     <= '0;
            tx_byte_q   <= '0;
            transmit_q  <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            write_en_q  <= 1'b0;
            startaddr_q <= '0;
            cpu_start_q <= 1'b0;
            running_q   <= 1'b0;
            tmo_q       <= '0;
`ifdef LOADER_READBACK_EN
            raddr_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            reply_q     <= reply_d;
            tx_byte_q   <= tx_byte_d;
            transmit_q  <= transmit_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            write_en_q  <= write_en_d;
            startaddr_q <= startaddr_d;
            cpu_start_q <= cpu_start_d;
            running_q   <= running_d;
            tmo_q       <= tmo_d;
`ifdef LOADER_READBACK_EN
            raddr_q     <= raddr_d;
`endif
        end
    end

    assign tx_byte     = tx_byte_q;
    assign transmit    = transmit_q;
    assign waddr       = waddr_q;
    assign wdata       = wdata_q;
    assign write_en    = write_en_q;
    assign startaddr   = startaddr_q;
    assign cpu_start   = cpu_start_q;
    assign cpu_running = running_q;
endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - directed self-checking bench for uart_loader
module tb_uart_loader;
    localparam int          AW = 9;
    localparam logic [23:0] TO = 24'd40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          received = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          is_transmitting = 1'b0;
    logic [7:0]    tx_byte;
    logic          transmit;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic          write_en;
    logic [AW-1:0] raddr;
    logic [7:0]    rdata = 8'h00;
    logic [AW-1:0] startaddr;
    logic          cpu_start;
    logic          cpu_halted = 1'b0;
    logic          cpu_running;

    int total = 0;
    int bad = 0;
    int busy = 0;
    int wr_cnt = 0;
    int start_cnt = 0;
    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] rd1 = 8'h00;
    logic [7:0] txq [$];

    uart_loader #(.addr_width(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .received(received), .rx_byte(rx_byte),
        .is_transmitting(is_transmitting), .tx_byte(tx_byte), .transmit(transmit),
        .waddr(waddr), .wdata(wdata), .write_en(write_en), .raddr(raddr), .rdata(rdata),
        .startaddr(startaddr), .cpu_start(cpu_start), .cpu_halted(cpu_halted),
        .cpu_running(cpu_running)
    );

    always #5 clk = ~clk;

    // UART transmitter (busy 5 clocks per byte), RAM with 2-clock read latency, strobe counters
    always @(negedge clk) begin
        if (transmit) begin
            txq.push_back(tx_byte);
            busy = 5;
        end else if (busy != 0) begin
            busy = busy - 1;
        end
        is_transmitting = (busy != 0);
        if (write_en) begin
            mem[waddr] = wdata;
            wr_cnt = wr_cnt + 1;
        end
        if (cpu_start) start_cnt = start_cnt + 1;
        rdata = rd1;
        rd1 = mem[raddr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [7:0] b);
        @(negedge clk);
        received = 1'b1;
        rx_byte  = b;
    endtask

    task automatic idle();
        @(negedge clk);
        received = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        pulse(b);
        idle();
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] b);
        logic [7:0] got;
        int cyc;
        got = 8'hxx;
        cyc = 0;
        while (txq.size() == 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (txq.size() != 0) got = txq.pop_front();
        chk(tag, {56'd0, got}, {56'd0, b});
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_a", {32'd0, tx_byte, transmit, waddr, wdata, write_en}, 64'd0);
        chk("rst_b", {32'd0, raddr, startaddr, cpu_start, cpu_running}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifndef LOADER_READBACK_EN
        // 'R' is not a command in the default build
        send(8'h52); send(8'h00); send(8'h10); send(8'h03);
        repeat (80) @(negedge clk);
        chk("r_ignored_tx", txq.size(), 0);
`endif

        // load 3 bytes with good checksum
        wr_cnt = 0;
        send(8'h4C); send(8'h00); send(8'h10); send(8'h03);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'h31);
        expect_tx("load_ack", 8'h06);
        chk("load_wr_cnt", wr_cnt, 3);
        chk("load_m10", mem[9'h010], 8'hAA);
        chk("load_m11", mem[9'h011], 8'hBB);
        chk("load_m12", mem[9'h012], 8'hCC);

`ifdef LOADER_READBACK_EN
        send(8'h52); send(8'h00); send(8'h10); send(8'h03);
        expect_tx("rb_0", 8'hAA);
        expect_tx("rb_1", 8'hBB);
        expect_tx("rb_2", 8'hCC);
        expect_tx("rb_ack", 8'h06);
`endif

        // bad checksum: byte kept, NAK, next 'L' accepted
        wr_cnt = 0;
        send(8'h4C); send(8'h00); send(8'h20); send(8'h01); send(8'h55); send(8'h00);
        expect_tx("bad_nak", 8'h15);
        chk("bad_m20", mem[9'h020], 8'h55);
        chk("bad_wr_cnt", wr_cnt, 1);
        send(8'h4C); send(8'h00); send(8'h30); send(8'h01); send(8'h77); send(8'h77);
        expect_tx("next_ack", 8'h06);
        chk("next_m30", mem[9'h030], 8'h77);

        // length 0 = 256 bytes, back-to-back pulses, address wrap 0x1FF -> 0x000
        wr_cnt = 0;
        send(8'h4C); send(8'h01); send(8'hFF); send(8'h00);
        for (int i = 0; i < 256; i++) pulse(8'(i));
        pulse(8'h80);
        idle();
        expect_tx("wrap_ack", 8'h06);
        chk("wrap_wr_cnt", wr_cnt, 256);
        chk("wrap_m1ff", mem[9'h1FF], 8'h00);
        for (int i = 1; i < 256; i++) chk("wrap_mem", {mem[9'(i - 1)], 8'(i - 1)}, {8'(i), 8'(i - 1)});
        chk("wrap_m0ff", mem[9'h0FF], 8'h00);

        // go, run, halt
        wr_cnt = 0;
        start_cnt = 0;
        send(8'h47); send(8'h00); send(8'h40);
        repeat (4) @(negedge clk);
        chk("go_start_cnt", start_cnt, 1);
        chk("go_running", cpu_running, 1);
        chk("go_startaddr", startaddr, 9'h040);
        send(8'h4C); send(8'h00); send(8'h50); send(8'h01); send(8'h99); send(8'h99);
        repeat (80) @(negedge clk);
        chk("run_no_wr", wr_cnt, 0);
        chk("run_no_tx", txq.size(), 0);
        chk("run_startaddr", startaddr, 9'h040);
        chk("run_start_cnt", start_cnt, 1);
        @(negedge clk);
        cpu_halted = 1'b1;
        @(negedge clk);
        cpu_halted = 1'b0;
        chk("halt_running", cpu_running, 0);
        expect_tx("halt_h", 8'h48);

        // timeout after partial command
        begin
            int cyc;
            send(8'h4C); send(8'h00);
            cyc = 0;
            while (txq.size() == 0 && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            chk("to_window", (cyc >= int'(TO) - 3 && cyc <= int'(TO) + 6), 1);
            expect_tx("to_nak", 8'h15);
        end
        send(8'h4C); send(8'h00); send(8'h60); send(8'h01); send(8'h12); send(8'h12);
        expect_tx("to_after_ack", 8'h06);
        chk("to_after_m60", mem[9'h060], 8'h12);

        // reset mid L_DATA
        send(8'h4C); send(8'h00); send(8'h70); send(8'h05); send(8'h11); send(8'h22);
        rst_n = 1'b0;
        #1;
        chk("midrst_a", {32'd0, tx_byte, transmit, waddr, wdata, write_en}, 64'd0);
        chk("midrst_b", {32'd0, raddr, startaddr, cpu_start, cpu_running}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_cnt = 0;
        repeat (80) @(negedge clk);
        chk("midrst_no_tx", txq.size(), 0);
        send(8'h33); send(8'h44);
        repeat (5) @(negedge clk);
        chk("midrst_idle_no_wr", wr_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Boot/monitor stage directly upstream of the cpu: owns the UART while the cpu is stopped.
- Receives a byte-serial command stream, writes program images into the shared RAM write port, then starts the cpu at a given address.
- Hands the UART to the cpu while it runs, and takes it back when the cpu reports halted.
- Top level muxes UART rx/tx between loader and cpu using cpu_running.

Parameters:
addr_width, 9, RAM address width; must match the cpu.
TIMEOUT_CYCLES, 24'd12000000, max idle clocks between bytes of one command before abort.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
received  in  1  UART rx strobe, one-cycle pulse
rx_byte  in  8  UART rx data, valid with received
is_transmitting  in  1  UART tx busy
tx_byte  out  8  UART tx data
transmit  out  1  UART tx strobe, one-cycle pulse
waddr  out  addr_width  RAM write address
wdata  out  8  RAM write data
write_en  out  1  RAM write enable, one-cycle pulse per byte
raddr  out  addr_width  RAM read address (used only with LOADER_READBACK_EN)
rdata  in  8  RAM read data, valid 2 clocks after raddr is registered
startaddr  out  addr_width  cpu start address
cpu_start  out  1  one-cycle pulse into the cpu rst input
cpu_halted  in  1  cpu halted pulse
cpu_running  out  1  1 = cpu owns the UART and the RAM write port

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; cpu_running=0.
  - All outputs 0; checksum, counters and timeout cleared.
  - Reset mid-command or mid-run discards everything. No reply is sent.
- Strobes: transmit, write_en and cpu_start default to 0 every cycle; each is high for exactly one clock when issued.
- Addresses: address = {hi,lo}[addr_width-1:0]; upper bits are ignored. The write address increments modulo 2^addr_width (wraps 0x1FF->0x000).
- IDLE: on received, decode rx_byte.
  - 0x4C 'L' -> L_AHI.
  - 0x47 'G' -> G_AHI.
  - 0x52 'R' -> R_AHI (macro only).
  - Any other byte is ignored.
- Load sequence: L_AHI -> L_ALO -> L_LEN -> L_DATA -> L_CSUM.
  - Each state advances on received.
  - len: 0 means 256 bytes.
  - L_DATA: each byte issues write_en with waddr=cur and wdata=rx_byte in the cycle after received. Then cur increments, sum += byte (mod 256) and cnt decrements; at cnt=0 -> L_CSUM.
  - L_CSUM: rx_byte==sum -> reply 0x06 (ACK); otherwise reply 0x15 (NAK). Bytes already written are not rolled back.
- Go sequence: G_AHI -> G_ALO -> START.
  - START: startaddr latched, cpu_start=1 for one clock, cpu_running=1 -> RUN.
  - RUN: all received strobes are ignored by the loader. On cpu_halted -> reply 0x48 'H', cpu_running=0 in the same cycle.
  - startaddr stays stable through RUN.
- REPLY:
  - Wait until is_transmitting=0, then tx_byte=reply and transmit=1 -> IDLE.
  - Exactly one reply per completed L, G or R command.
- Timeout:
  - A counter resets on every received strobe and counts in all states except IDLE, RUN and REPLY.
  - At TIMEOUT_CYCLES -> reply 0x15 NAK -> IDLE. A partial load keeps the bytes already written.
- Simultaneous events: received in the same cycle as a timeout expiry: the byte wins and the counter resets.
- Throughput: one byte per received pulse; pulses may arrive on consecutive clocks in L_DATA.

Optional Feature:
Macro LOADER_READBACK_EN.
- Defined:
  - 'R', ahi, alo, len (0=256) -> for each byte: set raddr, wait 2 clocks, wait !is_transmitting, transmit rdata, increment the address.
  - After the last data byte, reply ACK.
  - The timeout does not run during transmission.
- Undefined: raddr is held 0, rdata is unused, and 0x52 is ignored in IDLE.

Test Plan:
- Load: 4C 00 10 03 AA BB CC 31 -> writes 0x010=AA, 0x011=BB, 0x012=CC; 3 write_en pulses; tx 06.
- Bad checksum: 4C 00 20 01 55 00 -> 0x020=55 written; tx 15; next 'L' accepted normally.
- Wrap and length 0: 4C 01 FF 00 + 256 bytes + sum -> writes 0x1FF, then 0x000..0x0FE; tx 06.
- Go: 47 00 40 -> startaddr=0x040, one cpu_start pulse, cpu_running=1. Bytes 4C.. during RUN cause no writes. cpu_halted pulse -> tx 48, cpu_running=0.
- Timeout / reset: 4C 00 then silence for TIMEOUT_CYCLES -> tx 15, IDLE. Separately, rst_n low mid-L_DATA -> outputs 0, no reply, IDLE.
- Readback (macro): after load test, 52 00 10 03 -> tx AA BB CC 06, with is_transmitting held 5 clocks per byte.
